input_block_scheduler: RTL and testbench
========================================

INPUT_BLOCK_SCHEDULER -- requirements
Module: input_block_scheduler

Interface
REQ-001 SHALL have parameter IM_BLOCKS_MAX, default 64, maximum image blocks per layer; BW = clog2(IM_BLOCKS_MAX).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 2, maximum blocks issued but not yet completed (range 1..7).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 4096, watchdog limit (range >= 2).
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 aclk  in  1  clock, all logic on rising edge.
REQ-006 areset  in  1  synchronous active-high reset.
REQ-007 s_cfg_valid / s_cfg_ready  in / out  1 / 1  layer-config handshake.
REQ-008 s_cfg_blocks_1  in  BW  block count minus 1.
REQ-009 m_wcmd_valid / m_wcmd_ready  out / in  1 / 1  weight-fetch command handshake.
REQ-010 m_wcmd_block  out  BW  block index of the weight command.
REQ-011 m_pcmd_valid / m_pcmd_ready  out / in  1 / 1  pixel-fetch command handshake.
REQ-012 m_pcmd_block  out  BW  block index of the pixel command.
REQ-013 mon_valid, mon_ready, mon_last  in  1 each  tap of the joined pixel/weight conv stream.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 done  out  1  one-cycle layer-complete pulse.
REQ-016 err  out  1  sticky watchdog error.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, DRAIN, DONE.
REQ-018 In IDLE, s_cfg_ready SHALL be 1; a cfg handshake SHALL latch blocks_1, clear issue_idx and done_cnt, and move to ISSUE the next cycle.
REQ-019 In ISSUE, the scheduler SHALL present block issue_idx on both command ports while outstanding < MAX_OUTSTANDING, where outstanding = issue_idx - done_cnt.
REQ-020 Each command valid SHALL be held, with stable block index, until its own ready; the two ports SHALL complete independently, tracked by per-port sent flags.
REQ-021 issue_idx SHALL increment in the cycle in which the second of the two command handshakes for the current block completes; the sent flags SHALL then clear.
REQ-022 When issue_idx would exceed blocks_1, the FSM SHALL enter DRAIN with both command valids low.
REQ-023 A block completion is the condition mon_valid && mon_ready && mon_last; it SHALL increment done_cnt in ISSUE and DRAIN and SHALL be ignored in IDLE and DONE.
REQ-024 An issue and a completion in the same cycle SHALL leave outstanding unchanged, with no lost count.
REQ-025 When done_cnt reaches blocks_1+1, the FSM SHALL go to DONE; DONE SHALL assert done=1 for exactly one cycle and then return to IDLE.
REQ-026 With blocks_1=0, the scheduler SHALL issue exactly one command per port.
REQ-027 Counters SHALL be BW+1 bits wide so that the value blocks_1+1 = IM_BLOCKS_MAX is representable without wrap-around.
REQ-028 Latency from cfg handshake to first command valid SHALL be 1 cycle.

Reset
REQ-029 While areset is high, the FSM SHALL be in IDLE and every output SHALL be 0 (including s_cfg_ready, valids, blocks, busy, done and err); s_cfg_ready SHALL rise in the first cycle after reset deasserts.
REQ-030 An areset mid-layer SHALL abandon all counts; no done pulse SHALL follow.

Configuration
REQ-031 With macro INPUT_SCHED_TIMEOUT_EN defined, a watchdog SHALL count cycles in ISSUE/DRAIN and clear on any command handshake or mon beat.
REQ-032 With the macro defined, the watchdog SHALL set err when the count reaches TIMEOUT_CYCLES-1; err SHALL stay set until areset, and the FSM SHALL continue unaffected.
REQ-033 Without the macro, err SHALL be constant 0 and no watchdog logic SHALL exist.

Structure
REQ-034 A shared package SHALL hold the FSM state enum and the BW/counter-width localparam functions.
REQ-035 One sub-module, sched_cmd_slot (valid/ready holder with sent flag), SHALL be instantiated twice, once for the weight port and once for the pixel port.

Verification
REQ-036 blocks_1=3, both readies always 1, one mon_last every 10 cycles -> 4 commands per port with block 0,1,2,3; done pulses 1 cycle after the 4th mon_last.
REQ-037 MAX_OUTSTANDING=2, no mon_last -> exactly 2 blocks issued per port, then valids low; first mon_last releases block 2.
REQ-038 m_wcmd_ready held low 5 cycles while m_pcmd_ready=1 -> pcmd accepted once, wcmd valid/block stable 5 cycles, issue_idx increments only after wcmd is accepted.
REQ-039 Issue handshake and mon_last in same cycle at outstanding=2 -> next block issued the following cycle; done count correct.
REQ-040 Macro defined, TIMEOUT_CYCLES=16, stall all inputs -> err=1 at cycle 15 and remains 1; areset at block 2 -> all outputs 0, no done pulse.

Source files
------------

// File: rtl/input_block_scheduler_pkg.sv
// Shared types and width helpers for the input block scheduler.
package input_block_scheduler_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StDone
    } state_e;

    // Block-index width; at least one bit so a single-block layer still has a port.
    function automatic int calc_bw(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Counter width: one extra bit so blocks_1 + 1 == IM_BLOCKS_MAX does not wrap.
    function automatic int calc_cw(input int unsigned n);
        return calc_bw(n) + 1;
    endfunction

endpackage

// File: rtl/input_block_scheduler_slot.sv
// sched_cmd_slot: holds one command valid until its ready, then remembers it was sent.
module sched_cmd_slot #(
    parameter int unsigned BW = 6
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    input  logic          clr_i,
    input  logic [BW-1:0] block_i,
    input  logic          ready_i,
    output logic          valid_o,
    output logic [BW-1:0] block_o,
    output logic          sent_o
);

    logic sent_q, sent_d;
    logic fire;

    // Present the command only while enabled and not yet accepted for this block.
    always_comb begin
        valid_o = en_i & ~sent_q;
        block_o = valid_o ? block_i : '0;
        fire    = valid_o & ready_i;
        sent_o  = sent_q | fire;
        sent_d  = clr_i ? 1'b0 : (sent_q | fire);
    end

    // Sent flag register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sent_q <= 1'b0;
        end else begin
            sent_q <= sent_d;
        end
    end

endmodule

// File: rtl/input_block_scheduler.sv
// Input block scheduler: issues per-block weight/pixel fetch commands with a bounded
// number of blocks in flight, counts completions on the conv stream tap and pulses done.
// Optional watchdog enabled by defining INPUT_SCHED_TIMEOUT_EN.
module input_block_scheduler
    import input_block_scheduler_pkg::*;
#(
    parameter int unsigned IM_BLOCKS_MAX   = 64,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned TIMEOUT_CYCLES  = 4096,
    localparam int         BW              = calc_bw(IM_BLOCKS_MAX),
    localparam int         CW              = calc_cw(IM_BLOCKS_MAX)
) (
    input  logic          aclk,
    input  logic          areset,
    input  logic          s_cfg_valid,
    output logic          s_cfg_ready,
    input  logic [BW-1:0] s_cfg_blocks_1,
    output logic          m_wcmd_valid,
    input  logic          m_wcmd_ready,
    output logic [BW-1:0] m_wcmd_block,
    output logic          m_pcmd_valid,
    input  logic          m_pcmd_ready,
    output logic [BW-1:0] m_pcmd_block,
    input  logic          mon_valid,
    input  logic          mon_ready,
    input  logic          mon_last,
    output logic          busy,
    output logic          done,
    output logic          err
);

    state_e        state_q, state_d;
    logic [BW-1:0] blocks_1_q, blocks_1_d;
    logic [CW-1:0] issue_idx_q, issue_idx_d;
    logic [CW-1:0] done_cnt_q, done_cnt_d;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] total;
    logic          active;
    logic          issue_en;
    logic          issue_fire;
    logic          complete;
    logic          w_sent, p_sent;

    // Window and completion decode.
    always_comb begin
        outstanding = issue_idx_q - done_cnt_q;
        total       = CW'(blocks_1_q) + CW'(1);
        active      = (state_q == StIssue) || (state_q == StDrain);
        issue_en    = ~areset && (state_q == StIssue) && (32'(outstanding) < MAX_OUTSTANDING);
        issue_fire  = issue_en & w_sent & p_sent;
        complete    = mon_valid & mon_ready & mon_last & active;
    end

    sched_cmd_slot #(
        .BW (BW)
    ) u_wcmd_slot (
        .clk_i   (aclk),
        .rst_i   (areset),
        .en_i    (issue_en),
        .clr_i   (issue_fire),
        .block_i (issue_idx_q[BW-1:0]),
        .ready_i (m_wcmd_ready),
        .valid_o (m_wcmd_valid),
        .block_o (m_wcmd_block),
        .sent_o  (w_sent)
    );

    sched_cmd_slot #(
        .BW (BW)
    ) u_pcmd_slot (
        .clk_i   (aclk),
        .rst_i   (areset),
        .en_i    (issue_en),
        .clr_i   (issue_fire),
        .block_i (issue_idx_q[BW-1:0]),
        .ready_i (m_pcmd_ready),
        .valid_o (m_pcmd_valid),
        .block_o (m_pcmd_block),
        .sent_o  (p_sent)
    );

    // Next-state and counter updates; issue and completion in one cycle both count.
    always_comb begin
        state_d     = state_q;
        blocks_1_d  = blocks_1_q;
        issue_idx_d = issue_idx_q + CW'(issue_fire);
        done_cnt_d  = done_cnt_q + CW'(complete);
        unique case (state_q)
            StIdle: begin
                if (s_cfg_valid) begin
                    blocks_1_d  = s_cfg_blocks_1;
                    issue_idx_d = '0;
                    done_cnt_d  = '0;
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                if (issue_fire && (issue_idx_q == CW'(blocks_1_q))) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (done_cnt_d == total) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= StIdle;
            blocks_1_q  <= '0;
            issue_idx_q <= '0;
            done_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            blocks_1_q  <= blocks_1_d;
            issue_idx_q <= issue_idx_d;
            done_cnt_q  <= done_cnt_d;
        end
    end

    // Status outputs are forced low while reset is held.
    always_comb begin
        s_cfg_ready = ~areset && (state_q == StIdle);
        busy        = ~areset && (state_q != StIdle);
        done        = ~areset && (state_q == StDone);
    end

`ifdef INPUT_SCHED_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [WW-1:0] wd_q, wd_d;
    logic          err_q, err_d;
    logic          activity;

    // Watchdog: counts idle cycles while a layer is running; error is sticky.
    always_comb begin
        activity = (m_wcmd_valid & m_wcmd_ready) | (m_pcmd_valid & m_pcmd_ready) |
                   (mon_valid & mon_ready);
        wd_d     = '0;
        err_d    = err_q;
        if (active) begin
            if (activity) begin
                wd_d = '0;
            end else if (wd_q != WW'(TIMEOUT_CYCLES - 1)) begin
                wd_d = wd_q + WW'(1);
            end else begin
                wd_d = wd_q;
            end
            if (wd_q == WW'(TIMEOUT_CYCLES - 1)) begin
                err_d = 1'b1;
            end
        end
    end

    // Watchdog registers.
    always_ff @(posedge aclk) begin
        if (areset) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign err = err_q & ~areset;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_input_block_scheduler.sv
// Randomized scoreboard bench for input_block_scheduler (IM_BLOCKS_MAX = 8).
module tb_input_block_scheduler;

    localparam int IMB  = 8;
    localparam int MAXO = 2;
    localparam int BW   = 3;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic          s_cfg_valid = 1'b0;
    logic          s_cfg_ready;
    logic [BW-1:0] s_cfg_blocks_1 = '0;
    logic          m_wcmd_valid;
    logic          m_wcmd_ready = 1'b0;
    logic [BW-1:0] m_wcmd_block;
    logic          m_pcmd_valid;
    logic          m_pcmd_ready = 1'b0;
    logic [BW-1:0] m_pcmd_block;
    logic          mon_valid = 1'b0;
    logic          mon_ready = 1'b0;
    logic          mon_last = 1'b0;
    logic          busy;
    logic          done;
    logic          err;

    input_block_scheduler #(
        .IM_BLOCKS_MAX   (IMB),
        .MAX_OUTSTANDING (MAXO),
        .TIMEOUT_CYCLES  (16)
    ) dut (
        .aclk           (aclk),
        .areset         (areset),
        .s_cfg_valid    (s_cfg_valid),
        .s_cfg_ready    (s_cfg_ready),
        .s_cfg_blocks_1 (s_cfg_blocks_1),
        .m_wcmd_valid   (m_wcmd_valid),
        .m_wcmd_ready   (m_wcmd_ready),
        .m_wcmd_block   (m_wcmd_block),
        .m_pcmd_valid   (m_pcmd_valid),
        .m_pcmd_ready   (m_pcmd_ready),
        .m_pcmd_block   (m_pcmd_block),
        .mon_valid      (mon_valid),
        .mon_ready      (mon_ready),
        .mon_last       (mon_last),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int passes = 0;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endfunction

    // Reference model state, owned by the monitor.
    int  wq[$];
    int  pq[$];
    int  total = 0;
    int  w_cnt = 0;
    int  p_cnt = 0;
    int  comp_cnt = 0;
    bit  layer_on = 1'b0;
    bit  exp_done = 1'b0;
    bit  pw_pend = 1'b0;
    bit  pp_pend = 1'b0;
    int  pw_blk = 0;
    int  pp_blk = 0;

    // Monitor / scoreboard: observes handshakes just before the edge that commits them.
    always @(negedge aclk) begin
        int wc0, pc0, e;
        if (areset) begin
            layer_on = 1'b0;
            exp_done = 1'b0;
            pw_pend  = 1'b0;
            pp_pend  = 1'b0;
            wq.delete();
            pq.delete();
        end else begin
            if (done || exp_done) chk("done_pulse", int'(done), int'(exp_done));
            if (exp_done) begin
                chk("busy_in_done", int'(busy), 1);
                chk("all_cmds_issued", wq.size() + pq.size(), 0);
                exp_done = 1'b0;
                layer_on = 1'b0;
            end
            if (!layer_on && (m_wcmd_valid || m_pcmd_valid))
                chk("stray_cmd", int'(m_wcmd_valid | m_pcmd_valid), 0);
            if (pw_pend) chk("wcmd_hold", {m_wcmd_valid, m_wcmd_block}, {1'b1, pw_blk[BW-1:0]});
            if (pp_pend) chk("pcmd_hold", {m_pcmd_valid, m_pcmd_block}, {1'b1, pp_blk[BW-1:0]});
            pw_pend = m_wcmd_valid && !m_wcmd_ready;
            pw_blk  = int'(m_wcmd_block);
            pp_pend = m_pcmd_valid && !m_pcmd_ready;
            pp_blk  = int'(m_pcmd_block);
            if (m_wcmd_valid) chk("w_window", int'(w_cnt - comp_cnt < MAXO), 1);
            if (m_pcmd_valid) chk("p_window", int'(p_cnt - comp_cnt < MAXO), 1);
            wc0 = w_cnt;
            pc0 = p_cnt;
            if (m_wcmd_valid && m_wcmd_ready) begin
                e = (wq.size() > 0) ? wq.pop_front() : -1;
                chk("wcmd_block", int'(m_wcmd_block), e);
                chk("w_not_ahead", int'(wc0 <= pc0), 1);
                w_cnt++;
            end
            if (m_pcmd_valid && m_pcmd_ready) begin
                e = (pq.size() > 0) ? pq.pop_front() : -1;
                chk("pcmd_block", int'(m_pcmd_block), e);
                chk("p_not_ahead", int'(pc0 <= wc0), 1);
                p_cnt++;
            end
            if (layer_on && mon_valid && mon_ready && mon_last) begin
                comp_cnt++;
                if (comp_cnt == total) exp_done = 1'b1;
            end
            if (s_cfg_valid && s_cfg_ready) begin
                layer_on = 1'b1;
                total    = int'(s_cfg_blocks_1) + 1;
                w_cnt    = 0;
                p_cnt    = 0;
                comp_cnt = 0;
                wq.delete();
                pq.delete();
                for (int i = 0; i < total; i++) begin
                    wq.push_back(i);
                    pq.push_back(i);
                end
            end
        end
    end

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Call at posedge+1 with no layer running; returns at posedge+1 after the cfg handshake.
    task automatic start_cfg(input int b);
        int lim;
        s_cfg_valid    = 1'b1;
        s_cfg_blocks_1 = BW'(b);
        lim = 0;
        do begin
            @(posedge aclk);
            lim++;
        end while (!layer_on && lim < 50);
        #1;
        s_cfg_valid = 1'b0;
        chk("cfg_accept", int'(layer_on), 1);
    endtask

    // mode 0: random; 1: readies high, last every 10 cycles; 2: no beats for 20 cycles;
    // 3: weight ready low for the first 5 cycles.
    task automatic run_layer(input int b, input int mode);
        int  cyc;
        bit  allow;
        bit  beat;
        start_cfg(b);
        cyc = 0;
        while (layer_on && cyc < 3000) begin
            allow = (min2(w_cnt, p_cnt) - comp_cnt) > 0;
            if (mode == 2 && cyc == 20) begin
                chk("maxo_w_issued", w_cnt, MAXO);
                chk("maxo_p_issued", p_cnt, MAXO);
                chk("maxo_valids_low", int'(m_wcmd_valid | m_pcmd_valid), 0);
            end
            if (mode == 3 && cyc == 5) begin
                chk("wstall_p_once", p_cnt, 1);
                chk("wstall_w_none", w_cnt, 0);
            end
            case (mode)
                1: begin
                    m_wcmd_ready = 1'b1;
                    m_pcmd_ready = 1'b1;
                    beat = allow && (cyc % 10 == 9);
                    mon_valid = beat;
                    mon_ready = beat;
                    mon_last  = beat;
                end
                2: begin
                    m_wcmd_ready = 1'b1;
                    m_pcmd_ready = 1'b1;
                    beat = allow && (cyc >= 20) && ($urandom_range(0, 2) == 0);
                    mon_valid = beat;
                    mon_ready = beat;
                    mon_last  = beat;
                end
                3: begin
                    m_wcmd_ready = (cyc >= 5);
                    m_pcmd_ready = 1'b1;
                    beat = allow && ($urandom_range(0, 3) == 0);
                    mon_valid = beat;
                    mon_ready = beat;
                    mon_last  = beat;
                end
                default: begin
                    m_wcmd_ready = ($urandom_range(0, 3) != 0);
                    m_pcmd_ready = ($urandom_range(0, 3) != 0);
                    mon_valid    = $urandom_range(0, 1) == 1;
                    mon_ready    = $urandom_range(0, 1) == 1;
                    mon_last     = allow && ($urandom_range(0, 2) == 0);
                end
            endcase
            @(posedge aclk);
            #1;
            cyc++;
        end
        chk("layer_finished", int'(layer_on), 0);
        m_wcmd_ready = 1'b0;
        m_pcmd_ready = 1'b0;
        mon_valid = 1'b0;
        mon_ready = 1'b0;
        mon_last  = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
    endtask

    initial begin
        int done_seen;
        @(negedge aclk);
        chk("reset_outputs", {s_cfg_ready, m_wcmd_valid, m_wcmd_block, m_pcmd_valid,
                              m_pcmd_block, busy, done, err}, 0);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        @(negedge aclk);
        chk("cfg_ready_after_reset", int'(s_cfg_ready), 1);
        chk("idle_not_busy", int'(busy), 0);
        @(posedge aclk);
        #1;

        run_layer(3, 1);
        run_layer(7, 2);
        run_layer(4, 3);
        run_layer(0, 0);
        run_layer(7, 0);
        for (int i = 0; i < 10; i++) run_layer($urandom_range(0, IMB - 1), 0);

`ifdef INPUT_SCHED_TIMEOUT_EN
        start_cfg(4);
        repeat (40) @(posedge aclk);
        #1;
        chk("wd_err_set", int'(err), 1);
        repeat (5) @(posedge aclk);
        #1;
        chk("wd_err_sticky", int'(err), 1);
        chk("wd_fsm_running", int'(busy), 1);
        areset = 1'b1;
        @(posedge aclk);
        #1;
        areset = 1'b0;
        @(negedge aclk);
        chk("wd_err_cleared", int'(err), 0);
        @(posedge aclk);
        #1;
`endif

        // Abort a layer with blocks in flight.
        start_cfg(5);
        m_wcmd_ready = 1'b1;
        m_pcmd_ready = 1'b1;
        repeat (4) @(posedge aclk);
        #1;
        areset = 1'b1;
        @(negedge aclk);
        chk("reset_outputs_mid", {s_cfg_ready, m_wcmd_valid, m_wcmd_block, m_pcmd_valid,
                                  m_pcmd_block, busy, done, err}, 0);
        repeat (2) @(posedge aclk);
        #1;
        areset = 1'b0;
        mon_valid = 1'b1;
        mon_ready = 1'b1;
        mon_last  = 1'b1;
        @(negedge aclk);
        chk("cfg_ready_after_abort", int'(s_cfg_ready), 1);
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            if (done) done_seen++;
        end
        chk("no_done_after_abort", done_seen, 0);
        chk("idle_after_abort", int'(busy), 0);
        @(posedge aclk);
        #1;
        mon_valid = 1'b0;
        mon_ready = 1'b0;
        mon_last  = 1'b0;
        m_wcmd_ready = 1'b0;
        m_pcmd_ready = 1'b0;

        run_layer(2, 0);

`ifndef INPUT_SCHED_TIMEOUT_EN
        chk("err_const_low", int'(err), 0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
